// File: rtl/calc_pkg.sv
// Shared encodings for the keypad calculator sequencer: state codes, LED phase codes,
// the registered control-output bundle and the FSM transition/decode helpers.
package calc_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned OPS_W = 8;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t S_A_ENTRY = 3'd0;
  localparam state_t S_LOAD_A  = 3'd1;
  localparam state_t S_B_ENTRY = 3'd2;
  localparam state_t S_LOAD_B  = 3'd3;
  localparam state_t S_CALC    = 3'd4;
  localparam state_t S_RESULT  = 3'd5;
  localparam state_t S_ERROR   = 3'd6;

  localparam logic [1:0] LED_A   = 2'b00;
  localparam logic [1:0] LED_B   = 2'b01;
  localparam logic [1:0] LED_RES = 2'b10;
  localparam logic [1:0] LED_ERR = 2'b11;

  localparam logic [OPS_W-1:0] OPS_MAX = 8'd255;

  typedef struct packed {
    logic       ld_a;
    logic       ld_b;
    logic       ld_r;
    logic       ld_ou;
    logic       iu_au;
    logic       err;
    logic [1:0] led;
  } ctrl_t;

  // Moore output decode; load/calc states keep the LED of the phase being completed
  function automatic ctrl_t decode(input state_t st);
    ctrl_t c;
    c       = '0;
    c.iu_au = 1'b1;
    c.led   = LED_A;
    case (st)
      S_A_ENTRY: c.led = LED_A;
      S_LOAD_A:  c.ld_a = 1'b1;
      S_B_ENTRY: c.led = LED_B;
      S_LOAD_B:  begin c.ld_b = 1'b1; c.led = LED_B; end
      S_CALC:    begin c.ld_r = 1'b1; c.led = LED_B; end
      S_RESULT:  begin c.ld_ou = 1'b1; c.iu_au = 1'b0; c.led = LED_RES; end
      S_ERROR:   begin c.err = 1'b1; c.led = LED_ERR; end
      default:   c.led = LED_A;
    endcase
    return c;
  endfunction

  // key_invalid only matters in the cycle a press is presented
  function automatic state_t next_state(input state_t st, input logic press,
                                        input logic key_invalid);
    state_t nxt;
    nxt = st;
    case (st)
      S_A_ENTRY: if (press) nxt = key_invalid ? S_ERROR : S_LOAD_A;
      S_LOAD_A:  nxt = S_B_ENTRY;
      S_B_ENTRY: if (press) nxt = key_invalid ? S_ERROR : S_LOAD_B;
      S_LOAD_B:  nxt = S_CALC;
      S_CALC:    nxt = S_RESULT;
      S_RESULT:  if (press) nxt = S_A_ENTRY;
      S_ERROR:   if (press) nxt = S_A_ENTRY;
      default:   nxt = S_A_ENTRY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Enter-button conditioner: two-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted release->press transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_CNT_W        = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic                r_sync1;
  logic                r_sync2;
  logic                r_level;
  logic                r_level_d;
  logic                r_armed;
  logic                r_press;
  logic [1:0]          r_vld;
  logic [DB_CNT_W-1:0] r_cnt;
  logic [DB_CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + DB_CNT_W'(1);

  // r_armed blocks a press until the button has been seen released after reset,
  // so a button held through reset cannot fire; r_vld masks the reset-filled syncs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_level   <= 1'b1;
      r_level_d <= 1'b1;
      r_armed   <= 1'b0;
      r_press   <= 1'b0;
      r_vld     <= 2'b00;
      r_cnt     <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && r_sync2) begin
        r_armed <= 1'b1;
      end
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == DB_CNT_W'(DEBOUNCE_CYCLES)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
      r_level_d <= r_level;
      r_press   <= r_armed & r_level_d & ~r_level;
    end
  end

  assign press = r_press;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control: sequences A load, B load, result capture and display from
// debounced enter presses, and counts completed calculations.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter_n,
  input  logic             key_invalid,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_r,
  output logic             ld_ou,
  output logic             iu_au,
  output logic             err,
  output logic [1:0]       led,
  output logic [OPS_W-1:0] ops_done
);

  logic             w_press;
  state_t           w_next;
  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [OPS_W-1:0] r_ops;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_CNT_W        (DB_CNT_W)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .btn_n (enter_n),
    .press (w_press)
  );

  assign w_next = next_state(r_state, w_press, key_invalid);

  // Outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_A_ENTRY;
      r_ctrl  <= decode(S_A_ENTRY);
      r_ops   <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next);
      if (r_state == S_CALC && r_ops != OPS_MAX) begin
        r_ops <= r_ops + OPS_W'(1);
      end
    end
  end

  assign ld_a     = r_ctrl.ld_a;
  assign ld_b     = r_ctrl.ld_b;
  assign ld_r     = r_ctrl.ld_r;
  assign ld_ou    = r_ctrl.ld_ou;
  assign iu_au    = r_ctrl.iu_au;
  assign err      = r_ctrl.err;
  assign led      = r_ctrl.led;
  assign ops_done = r_ops;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: press-sequence table, bounce/reset/saturation sequences and
// random button/key_invalid stimulus, all checked every cycle against a behavioural model.
module tb_calc_sequencer;

  localparam int unsigned DC = 4;
  localparam int PH_A = 0, PH_B = 1, PH_RES = 2, PH_ERR = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter_n = 1'b1;
  logic       key_invalid = 1'b0;
  logic       ld_a, ld_b, ld_r, ld_ou, iu_au, err;
  logic [1:0] led;
  logic [7:0] ops_done;

  calc_sequencer #(.DEBOUNCE_CYCLES(DC), .DB_CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enter_n(enter_n), .key_invalid(key_invalid),
    .ld_a(ld_a), .ld_b(ld_b), .ld_r(ld_r), .ld_ou(ld_ou), .iu_au(iu_au), .err(err),
    .led(led), .ops_done(ops_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_lda = 0, n_ldb = 0, n_ldr = 0, lda_cyc = 0;

  // behavioural model state
  bit          model_on = 0;
  int          phase, cnt_m, since_rst;
  bit          acc_m, armed_m, p_acc, p_vis, last_trans;
  bit          sq[$];
  logic [15:0] q[$];
  logic [15:0] exp_v;

  function automatic logic [15:0] rec(input bit a, input bit b, input bit r, input bit ou,
                                      input bit iu, input bit er, input logic [1:0] l,
                                      input int ops);
    return {a, b, r, ou, iu, er, l, 8'(ops)};
  endfunction

  function automatic logic [15:0] steady(input int ph, input int c);
    case (ph)
      PH_A:    return rec(0, 0, 0, 0, 1, 0, 2'd0, c);
      PH_B:    return rec(0, 0, 0, 0, 1, 0, 2'd1, c);
      PH_RES:  return rec(0, 0, 0, 1, 0, 0, 2'd2, c);
      default: return rec(0, 0, 0, 0, 1, 1, 2'd3, c);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock: sample inputs as seen by this edge, advance the model, compare all outputs
  task automatic tick();
    bit s, rs, ki, v, all, act;
    logic [15:0] act_v;
    @(posedge clock);
    #1;
    cyc++;
    s  = enter_n;
    rs = reset;
    ki = key_invalid;
    act = 0;
    if (rs) begin
      model_on = 1; phase = PH_A; cnt_m = 0; acc_m = 1; armed_m = 0; since_rst = 0;
      sq.delete();
      for (int i = 0; i < DC + 2; i++) sq.push_back(1'b1);
      p_acc = 0; p_vis = 0; last_trans = 0;
      q.delete();
      exp_v = steady(PH_A, 0);
    end else if (model_on) begin
      since_rst++;
      act = p_vis; p_vis = p_acc; p_acc = 0;
      if (act && !last_trans) begin
        case (phase)
          PH_A: if (ki) phase = PH_ERR;
                else begin q.push_back(rec(1, 0, 0, 0, 1, 0, 2'd0, cnt_m)); phase = PH_B; end
          PH_B: if (ki) phase = PH_ERR;
                else begin
                  q.push_back(rec(0, 1, 0, 0, 1, 0, 2'd1, cnt_m));
                  q.push_back(rec(0, 0, 1, 0, 1, 0, 2'd1, cnt_m));
                  if (cnt_m < 255) cnt_m++;
                  phase = PH_RES;
                end
          default: phase = PH_A;
        endcase
      end
      if (q.size() > 0) begin exp_v = q.pop_front(); last_trans = 1; end
      else begin exp_v = steady(phase, cnt_m); last_trans = 0; end
      // button: accepted level flips once DC consecutive samples disagree with it
      sq.push_back(s);
      if (sq.size() > DC + 2) void'(sq.pop_front());
      v = sq[DC - 1];
      all = 1;
      for (int i = 0; i < DC; i++) if (sq[i] != v) all = 0;
      if (v != acc_m && all) begin
        acc_m = v;
        if (!v && armed_m) p_acc = 1;
      end
      if (v && since_rst >= 3) armed_m = 1;
    end
    if (model_on) begin
      act_v = {ld_a, ld_b, ld_r, ld_ou, iu_au, err, led, ops_done};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL model cycle %0d: got lda/ldb/ldr/ou/iu/err=%b led=%b ops=%0d expected %b led=%b ops=%0d",
                 cyc, act_v[15:10], act_v[9:8], act_v[7:0], exp_v[15:10], exp_v[9:8], exp_v[7:0]);
      end
      if (ld_a) begin n_lda++; lda_cyc = cyc; end
      if (ld_b) n_ldb++;
      if (ld_r) n_ldr++;
    end
  endtask

  task automatic press(input bit inv);
    enter_n = 1'b0; key_invalid = inv;
    repeat (10) tick();
    enter_n = 1'b1; key_invalid = 1'b0;
    repeat (10) tick();
  endtask

  typedef struct {
    bit         inv;
    logic [1:0] led;
    bit         err;
    bit         ou;
    int         ops;
  } vec_t;

  vec_t tbl[11];
  int   base_a, base_b, last_edge;

  initial begin
    tbl[0]  = '{0, 2'd1, 0, 0, 0};
    tbl[1]  = '{0, 2'd2, 0, 1, 1};
    tbl[2]  = '{0, 2'd0, 0, 0, 1};
    tbl[3]  = '{0, 2'd1, 0, 0, 1};
    tbl[4]  = '{1, 2'd3, 1, 0, 1};
    tbl[5]  = '{0, 2'd0, 0, 0, 1};
    tbl[6]  = '{1, 2'd3, 1, 0, 1};
    tbl[7]  = '{1, 2'd0, 0, 0, 1};
    tbl[8]  = '{0, 2'd1, 0, 0, 1};
    tbl[9]  = '{0, 2'd2, 0, 1, 2};
    tbl[10] = '{1, 2'd0, 0, 0, 2};

    // reset
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_iu_au", int'(iu_au), 1);
    check("rst_led", int'(led), 0);
    check("rst_strobes", int'({ld_a, ld_b, ld_r, ld_ou, err}), 0);
    check("rst_ops", int'(ops_done), 0);
    repeat (8) tick();

    // press table: calculations, invalid keys at A and B, ignored key_invalid elsewhere
    foreach (tbl[i]) begin
      press(tbl[i].inv);
      check($sformatf("tbl%0d_led", i), int'(led), int'(tbl[i].led));
      check($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
      check($sformatf("tbl%0d_ld_ou", i), int'(ld_ou), int'(tbl[i].ou));
      check($sformatf("tbl%0d_ops", i), int'(ops_done), tbl[i].ops);
    end
    check("cnt_ld_a", n_lda, 3);
    check("cnt_ld_b", n_ldb, 2);
    check("cnt_ld_r", n_ldr, 2);

    // bounce: 2-cycle glitches for 20 cycles, then held low
    base_a = n_lda;
    for (int i = 0; i < 10; i++) begin
      enter_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    enter_n = 1'b0;
    last_edge = cyc;
    repeat (20) tick();
    check("bounce_presses", n_lda - base_a, 1);
    check("bounce_latency", lda_cyc - last_edge, int'(DC) + 4);
    enter_n = 1'b1;
    repeat (12) tick();
    press(0);
    press(0);
    check("bounce_calc_ops", int'(ops_done), 3);

    // reset in the cycle before ld_b, with enter held low across it
    press(0);
    base_a = n_lda;
    base_b = n_ldb;
    enter_n = 1'b0;
    repeat (DC + 3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (40) tick();
    check("midrst_ld_b", n_ldb - base_b, 0);
    check("midrst_led", int'(led), 0);
    check("midrst_ops", int'(ops_done), 0);
    check("midrst_held_nopress", n_lda - base_a, 0);
    enter_n = 1'b1;
    repeat (12) tick();
    press(0);
    check("midrst_repress", n_lda - base_a, 1);
    check("midrst_repress_led", int'(led), 1);

    // saturation: 256 calculations from ops_done = 0
    press(0);
    press(0);
    for (int i = 2; i <= 256; i++) begin
      press(0);
      press(0);
      if (i >= 254) check($sformatf("sat_ops_%0d", i), int'(ops_done), (i > 255) ? 255 : i);
      press(0);
    end
    check("sat_final", int'(ops_done), 255);

    // random bounce and key_invalid
    for (int n = 0; n < 500; n++) begin
      enter_n = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 9)) begin
        key_invalid = 1'($urandom_range(0, 1));
        tick();
      end
    end
    enter_n = 1'b1;
    key_invalid = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
